alu_serial_scheduler: RTL
=========================

// Module: alu_serial_scheduler
// PURPOSE
//  Shares one serial ALU (sin/sout frame link) among N_REQ requesters.
//  - Round-robin arbitration between requesters.
//  - Builds the 9-frame command packet (B, A, CTL with CRC4) and drives sin.
//  - Parses the ALU reply on sout and returns result/flags/error, tagged with requester id.
//  - Sits between the ALU core and on-chip clients; replaces the bench tester as the ALU's sequencer.
// PARAMETERS
//  N_REQ    2     number of requesters (>=2); ID_W = $clog2(N_REQ) derived localparam
//  TIMEOUT  2000  cycles to wait for reply start bit before declaring fault
// PORTS
//  clk            in   1         system clock, all logic rising edge
//  rst_n          in   1         asynchronous active-low reset
//  req_valid      in   N_REQ     per-requester request; held until req_ready
//  req_ready      out  N_REQ     one-hot 1-cycle grant/accept pulse
//  req_a          in   32*N_REQ  operand A, slice i for requester i
//  req_b          in   32*N_REQ  operand B
//  req_op         in   3*N_REQ   op: AND=000 OR=001 ADD=100 SUB=101; others sent as-is
//  sin            out  1         serial to ALU, idle 1
//  sout           in   1         serial from ALU, idle 1
//  busy           out  1         1 from grant until rsp_valid cycle inclusive
//  rsp_valid      out  1         1-cycle response pulse
//  rsp_id         out  ID_W      granted requester index
//  rsp_c          out  32        result C
//  rsp_flags      out  4         {carry,overflow,zero,negative}
//  rsp_err        out  1         ALU returned error frame
//  rsp_err_flags  out  6         {ERR_DATA,ERR_CRC,ERR_OP,ERR_DATA,ERR_CRC,ERR_OP} from error frame
//  rsp_fault      out  1         timeout or framing error (stop bit 0) on reply
//  rsp_crc_bad    out  1         reply CRC3 mismatch (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0, except sin=1. FSM=IDLE, rr pointer=0, all counters 0.
//  Frame: 11 bits MSB-first: 0, type(0=data,1=ctl), d[7:0], 1. One bit per clk.
//  FSM IDLE->GRANT->SEND->WAIT->RECV->DONE->IDLE.
//   IDLE: any req_valid -> GRANT.
//   GRANT (1 cycle): pick first valid at/after rr ptr; pulse req_ready[i]; latch a,b,op,id;
//    rr ptr = i+1 mod N_REQ; busy=1.
//   SEND: first start bit on the cycle after GRANT. Frames: B[31:24]..B[7:0], A[31:24]..A[7:0],
//    CTL {0,op,crc4}. crc4 = CRC-4 (x^4+x+1, init 0) over 68 bits {B,A,1'b1,op}.
//    99 cycles total; sin=1 after last stop bit.
//   WAIT: timeout counter counts from the cycle after the last stop bit. sout=0 -> RECV.
//    Counter reaching TIMEOUT -> DONE with rsp_fault=1.
//   RECV: shift 10 bits after the start bit; the next start is searched after each stop bit.
//    type=1 and d[7]=1: error frame; rsp_err=1, rsp_err_flags=d[6:1] -> DONE.
//    type=0: data byte (C MSB-first); after 4 data frames expect ctl {0,flags,crc3}.
//    Flags latched -> DONE.
//    Stop bit 0, or ctl type in a data position -> DONE with rsp_fault=1.
//    Data type in the ctl position -> DONE with rsp_fault=1.
//    Inter-frame gap on sout is also bounded by TIMEOUT (fault on expiry).
//   DONE: rsp_valid=1 for 1 cycle; rsp_* stable until next DONE; busy drops next cycle.
//  No new grant until DONE; req_valid during busy is held pending (not lost).
//  Simultaneous requests: strict round-robin; after reset requester 0 wins.
//  Mid-operation rst_n: immediate abort, sin=1, no rsp_valid; the packet is lost.
//  sout is treated as synchronous to clk (no synchroniser).
// CONFIGURATION
//  ALU_SCHED_RSP_CRC_EN defined:
//   - On a normal reply, compute CRC-3 (x^3+x+1, init 0) over 37 bits {C,1'b0,flags}.
//   - Mismatch with received crc3 -> rsp_crc_bad=1 alongside rsp_valid; result still reported.
//  ALU_SCHED_RSP_CRC_EN undefined: crc3 field ignored; rsp_crc_bad tied 0.
// TESTING
//  1 req0 ADD A=1 B=2: sin shows 9 frames, CTL = {0,100,crc4(ref model)}; ALU model replies C=3,
//    flags=0000 -> rsp_valid, rsp_id=0, rsp_c=32'h3, rsp_err=0.
//  2 req0,req1 valid same cycle after reset: grants req0 then req1; req0 reasserted -> req1,req0 order
//    not taken, req0 is next (rr) -> ready order 0,1,0.
//  3 op=3'b010 A=B=FFFF_FFFF: ALU model returns error frame d=1_001001_x -> rsp_err=1,
//    rsp_err_flags=6'b001001.
//  4 sout held 1: rsp_valid with rsp_fault=1 exactly TIMEOUT cycles after last sin stop bit.
//  5 rst_n low during SEND frame 4: sin=1 and busy=0 same edge, no rsp_valid;
//    after release a new request completes normally.
//  6 Macro on: reply crc3 XOR 1 -> rsp_crc_bad=1, rsp_c correct; macro off, same stimulus -> rsp_crc_bad=0.

Source files
------------

// File: rtl/alu_serial_scheduler_if.sv
// Client-side bundle for alu_serial_scheduler: per-requester request lanes plus the shared response.
interface alu_serial_scheduler_if #(
    parameter int N_REQ = 2
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0][31:0] req_a;
    logic [N_REQ-1:0][31:0] req_b;
    logic [N_REQ-1:0][2:0]  req_op;
    logic                   busy;
    logic                   rsp_valid;
    logic [ID_W-1:0]        rsp_id;
    logic [31:0]            rsp_c;
    logic [3:0]             rsp_flags;
    logic                   rsp_err;
    logic [5:0]             rsp_err_flags;
    logic                   rsp_fault;
    logic                   rsp_crc_bad;

    modport master (
        output req_valid, req_a, req_b, req_op,
        input  req_ready, busy, rsp_valid, rsp_id, rsp_c, rsp_flags,
               rsp_err, rsp_err_flags, rsp_fault, rsp_crc_bad
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op,
        output req_ready, busy, rsp_valid, rsp_id, rsp_c, rsp_flags,
               rsp_err, rsp_err_flags, rsp_fault, rsp_crc_bad
    );
endinterface

// File: rtl/alu_serial_scheduler.sv
// Round-robin sequencer sharing one serial-frame ALU among N_REQ clients.
// Reply CRC-3 checking is built only when ALU_SCHED_RSP_CRC_EN is defined.
module alu_serial_scheduler #(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 2000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_serial_scheduler_if.slave bus,
    output logic                  sin,
    input  logic                  sout
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int PKT_W = 99;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, GRANT, SEND, WAIT, RECV, DONE} state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
    } req_t;

    state_t           state;
    logic [ID_W-1:0]  rr, cur_id, pick, rr_nxt;
    logic             pick_ok;
    req_t             sel;
    logic [PKT_W-1:0] tx_sr, pkt;
    logic [6:0]       cnt;
    logic [TMO_W-1:0] tmo;
    logic [8:0]       rx_sr;
    logic [2:0]       rx_frm;
    logic [31:0]      c_acc;
    logic [9:0]       fr;
    logic [7:0]       f_d;
    logic             f_type, f_stop, is_err, is_data, is_ctl, crc_bad;

    function automatic logic [3:0] crc4(input logic [67:0] msg);
        logic [3:0] c;
        logic       fb;
        c = '0;
        for (int i = 67; i >= 0; i--) begin
            fb = msg[i] ^ c[3];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

    function automatic logic [10:0] frame(input logic typ, input logic [7:0] d);
        return {1'b0, typ, d, 1'b1};
    endfunction

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        int idx;
        idx     = 0;
        pick    = '0;
        pick_ok = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr) + k) % N_REQ;
            if (!pick_ok && bus.req_valid[idx]) begin
                pick    = ID_W'(idx);
                pick_ok = 1'b1;
            end
        end
    end

    assign rr_nxt = (int'(pick) == N_REQ - 1) ? '0 : pick + 1'b1;
    assign sel    = '{a: bus.req_a[pick], b: bus.req_b[pick], op: bus.req_op[pick]};

    // Whole command packet is prepared at grant and then just shifted out.
    always_comb begin
        logic [7:0] ctl;
        ctl = {1'b0, sel.op, crc4({sel.b, sel.a, 1'b1, sel.op})};
        pkt = {frame(1'b0, sel.b[31:24]), frame(1'b0, sel.b[23:16]),
               frame(1'b0, sel.b[15:8]),  frame(1'b0, sel.b[7:0]),
               frame(1'b0, sel.a[31:24]), frame(1'b0, sel.a[23:16]),
               frame(1'b0, sel.a[15:8]),  frame(1'b0, sel.a[7:0]),
               frame(1'b1, ctl)};
    end

    assign fr      = {rx_sr, sout};
    assign f_type  = fr[9];
    assign f_d     = fr[8:1];
    assign f_stop  = fr[0];
    assign is_err  = f_stop && f_type && f_d[7];
    assign is_data = f_stop && !f_type && (rx_frm < 3'd4);
    assign is_ctl  = f_stop && f_type && !f_d[7] && (rx_frm == 3'd4);

`ifdef ALU_SCHED_RSP_CRC_EN
    function automatic logic [2:0] crc3(input logic [36:0] msg);
        logic [2:0] c;
        logic       fb;
        c = '0;
        for (int i = 36; i >= 0; i--) begin
            fb = msg[i] ^ c[2];
            c  = {c[1:0], 1'b0} ^ {1'b0, fb, fb};
        end
        return c;
    endfunction

    assign crc_bad = is_ctl && (crc3({c_acc, 1'b0, f_d[6:3]}) != f_d[2:0]);
`else
    logic crc_unused;
    assign crc_unused = f_d[0];
    assign crc_bad    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            rr                <= '0;
            cur_id            <= '0;
            tx_sr             <= '0;
            cnt               <= '0;
            tmo               <= '0;
            rx_sr             <= '0;
            rx_frm            <= '0;
            c_acc             <= '0;
            sin               <= 1'b1;
            bus.req_ready     <= '0;
            bus.busy          <= 1'b0;
            bus.rsp_valid     <= 1'b0;
            bus.rsp_id        <= '0;
            bus.rsp_c         <= '0;
            bus.rsp_flags     <= '0;
            bus.rsp_err       <= 1'b0;
            bus.rsp_err_flags <= '0;
            bus.rsp_fault     <= 1'b0;
            bus.rsp_crc_bad   <= 1'b0;
        end else begin
            bus.req_ready <= '0;
            bus.rsp_valid <= 1'b0;
            case (state)
                IDLE: if (pick_ok) begin
                    state         <= GRANT;
                    bus.req_ready <= N_REQ'(1) << pick;
                    bus.busy      <= 1'b1;
                    tx_sr         <= pkt;
                    cur_id        <= pick;
                    rr            <= rr_nxt;
                    c_acc         <= '0;
                    rx_frm        <= '0;
                end
                GRANT: begin
                    sin   <= tx_sr[PKT_W-1];
                    tx_sr <= {tx_sr[PKT_W-2:0], 1'b0};
                    cnt   <= '0;
                    state <= SEND;
                end
                SEND: if (cnt == 7'(PKT_W - 1)) begin
                    sin   <= 1'b1;
                    tmo   <= TMO_W'(1);
                    state <= WAIT;
                end else begin
                    sin   <= tx_sr[PKT_W-1];
                    tx_sr <= {tx_sr[PKT_W-2:0], 1'b0};
                    cnt   <= cnt + 7'd1;
                end
                // Used both before the first reply frame and between frames.
                WAIT: if (!sout) begin
                    cnt   <= '0;
                    state <= RECV;
                end else if (tmo >= TMO_W'(TIMEOUT - 1)) begin
                    state             <= DONE;
                    bus.rsp_valid     <= 1'b1;
                    bus.rsp_id        <= cur_id;
                    bus.rsp_c         <= c_acc;
                    bus.rsp_flags     <= '0;
                    bus.rsp_err       <= 1'b0;
                    bus.rsp_err_flags <= '0;
                    bus.rsp_fault     <= 1'b1;
                    bus.rsp_crc_bad   <= 1'b0;
                end else begin
                    tmo <= tmo + 1'b1;
                end
                RECV: begin
                    rx_sr <= {rx_sr[7:0], sout};
                    if (cnt != 7'd9) begin
                        cnt <= cnt + 7'd1;
                    end else if (is_data) begin
                        c_acc  <= {c_acc[23:0], f_d};
                        rx_frm <= rx_frm + 3'd1;
                        tmo    <= TMO_W'(1);
                        state  <= WAIT;
                    end else begin
                        state             <= DONE;
                        bus.rsp_valid     <= 1'b1;
                        bus.rsp_id        <= cur_id;
                        bus.rsp_c         <= c_acc;
                        bus.rsp_flags     <= is_ctl ? f_d[6:3] : 4'd0;
                        bus.rsp_err       <= is_err;
                        bus.rsp_err_flags <= is_err ? f_d[6:1] : 6'd0;
                        bus.rsp_fault     <= !(is_err || is_ctl);
                        bus.rsp_crc_bad   <= crc_bad;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
